// File: rtl/nes_controller_poller.sv
// nes_controller_poller: periodic fetch scheduler with per-controller
// debounce and a small press/release event FIFO.
module nes_controller_poller #(
   parameter int NUM_CONTROLLERS  = 4,
   parameter int POLL_PERIOD      = 200000,
   parameter int DEBOUNCE_SAMPLES = 2,
   parameter int FETCH_TIMEOUT    = 4096,
   parameter int FIFO_DEPTH       = 4,
   localparam int KW = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_ni,
   input  logic                         enable_i,
   output logic                         start_fetch_o,
   input  logic                         fetch_valid_i,
   input  logic [8*NUM_CONTROLLERS-1:0] data_LIST_i,
   output logic [8*NUM_CONTROLLERS-1:0] buttons_LIST_o,
   output logic                         event_valid_o,
   input  logic                         event_ready_i,
   output logic [KW-1:0]                event_controller_o,
   output logic [7:0]                   event_pressed_o,
   output logic [7:0]                   event_released_o,
   output logic                         overflow_o,
   output logic                         timeout_o,
   input  logic                         clear_flags_i
);
   localparam int N  = NUM_CONTROLLERS;
   localparam int W  = 8 * N;
   localparam int PW = $clog2(POLL_PERIOD);
   localparam int TW = $clog2(FETCH_TIMEOUT);
   localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = KW + 16;

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT, PROCESS} state_t;

   state_t state, state_d;

   logic [PW-1:0] pcnt;
   logic          pending;
   logic          fv_q;
   logic [TW-1:0] tcnt;
   logic [KW-1:0] idx;
   logic [7:0]    raw   [N];
   logic [7:0]    cand  [N];
   logic [DW-1:0] cnt   [N];
   logic [7:0]    stab  [N];

   logic          tick;
   logic          go;
   logic          fetch_edge;
   logic          tmo;
   logic          last;
   logic          take;
   logic          capture;
   logic          proc;
   logic          tmo_set;

   logic [7:0]    cur;
   logic [DW-1:0] cnt_new;
   logic          push;
   logic [EW-1:0] ev;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;

   assign tick       = (pcnt == '0);
   assign go         = enable_i && (pending || tick);
   assign fetch_edge = fetch_valid_i && !fv_q;
   // The REQUEST cycle counts toward the fetch timeout.
   assign tmo        = (tcnt == TW'(FETCH_TIMEOUT - 2));
   assign last       = (idx == KW'(N - 1));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d       = state;
      start_fetch_o = 1'b0;
      take          = 1'b0;
      capture       = 1'b0;
      proc          = 1'b0;
      tmo_set       = 1'b0;
      unique case (state)
         IDLE: begin
            if (go) begin
               take    = 1'b1;
               state_d = REQUEST;
            end
         end
         REQUEST: begin
            start_fetch_o = 1'b1;
            state_d       = WAIT;
         end
         WAIT: begin
            if (fetch_edge) begin
               capture = 1'b1;
               state_d = PROCESS;
            end else if (tmo) begin
               tmo_set = 1'b1;
               state_d = IDLE;
            end
         end
         PROCESS: begin
            proc = 1'b1;
            if (last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         pcnt    <= PW'(POLL_PERIOD - 1);
         pending <= 1'b0;
         fv_q    <= 1'b0;
         tcnt    <= '0;
         idx     <= '0;
      end else begin
         pcnt <= tick ? PW'(POLL_PERIOD - 1) : pcnt - 1'b1;
         fv_q <= fetch_valid_i;
         if (take)      pending <= 1'b0;
         else if (tick) pending <= 1'b1;
         if (state == REQUEST)   tcnt <= '0;
         else if (state == WAIT) tcnt <= tcnt + 1'b1;
         if (capture)   idx <= '0;
         else if (proc) idx <= idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N; k++) raw[k] <= '0;
      end else if (capture) begin
         for (int k = 0; k < N; k++) raw[k] <= data_LIST_i[W-1-8*k -: 8];
      end
   end

   always_comb begin
      cur     = raw[idx];
      cnt_new = DW'(1);
      if (cur == cand[idx]) begin
         if (cnt[idx] == DW'(DEBOUNCE_SAMPLES)) cnt_new = cnt[idx];
         else                                   cnt_new = cnt[idx] + 1'b1;
      end
      push = proc && (cnt_new == DW'(DEBOUNCE_SAMPLES)) && (cur != stab[idx]);
      ev   = {idx, cur & ~stab[idx], ~cur & stab[idx]};
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N; k++) begin
            cand[k] <= '0;
            cnt[k]  <= '0;
            stab[k] <= '0;
         end
      end else if (proc) begin
         cand[idx] <= cur;
         cnt[idx]  <= cnt_new;
         if (push) stab[idx] <= cur;
      end
   end

   always_comb begin
      buttons_LIST_o = '0;
      for (int k = 0; k < N; k++) buttons_LIST_o[W-1-8*k -: 8] = stab[k];
   end

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign pop     = event_ready_i && !empty;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wp] <= ev;
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop)     rp <= rp + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      end
   end

   // Head fields are forced to zero while empty so reset drives all outputs low.
   assign event_valid_o      = !empty;
   assign event_controller_o = empty ? '0 : mem[rp][EW-1 -: KW];
   assign event_pressed_o    = empty ? '0 : mem[rp][15:8];
   assign event_released_o   = empty ? '0 : mem[rp][7:0];

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_o <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         if (drop)               overflow_o <= 1'b1;
         else if (clear_flags_i) overflow_o <= 1'b0;
         if (tmo_set)            timeout_o  <= 1'b1;
         else if (clear_flags_i) timeout_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nes_controller_poller.sv
// tb_nes_controller_poller: directed polls against a timeline model of
// request/fetch/debounce/FIFO behaviour, compared every cycle.
module tb_nes_controller_poller;
   localparam int N   = 4;
   localparam int PER = 16;
   localparam int DEB = 2;
   localparam int TMO = 8;
   localparam int FD  = 2;
   localparam int W   = 8 * N;
   localparam int INF = 1 << 30;

   logic         clk;
   logic         rst_ni;
   logic         enable;
   logic         start_fetch;
   logic         fetch_valid;
   logic [W-1:0] data;
   logic [W-1:0] buttons;
   logic         event_valid;
   logic         event_ready;
   logic [1:0]   event_controller;
   logic [7:0]   event_pressed;
   logic [7:0]   event_released;
   logic         overflow;
   logic         timeout;
   logic         clear_flags;

   nes_controller_poller #(
      .NUM_CONTROLLERS(N), .POLL_PERIOD(PER), .DEBOUNCE_SAMPLES(DEB),
      .FETCH_TIMEOUT(TMO), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_ni(rst_ni), .enable_i(enable),
      .start_fetch_o(start_fetch), .fetch_valid_i(fetch_valid),
      .data_LIST_i(data), .buttons_LIST_o(buttons),
      .event_valid_o(event_valid), .event_ready_i(event_ready),
      .event_controller_o(event_controller),
      .event_pressed_o(event_pressed), .event_released_o(event_released),
      .overflow_o(overflow), .timeout_o(timeout),
      .clear_flags_i(clear_flags)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Interface stand-in: answers each request three cycles later.
   logic [W-1:0] raw;
   bit           resp_on;

   initial begin
      fetch_valid = 1'b0;
      data        = '0;
      forever begin
         @(negedge clk);
         if (rst_ni && start_fetch && resp_on) begin
            repeat (3) @(negedge clk);
            data        = raw;
            fetch_valid = 1'b1;
            @(negedge clk);
            fetch_valid = 1'b0;
         end
      end
   end

   typedef struct {
      int         k;
      logic [7:0] p;
      logic [7:0] r;
   } ev_t;

   ev_t        q[$];
   int         m_cyc, m_req, m_free;
   bit         m_pend, m_wait, m_req_now, m_ov, m_to, fv_prev;
   logic [7:0] m_cand[N], m_stab[N], m_cap[N];
   int         m_cnt[N], m_upd[N];

   task automatic model_reset();
      q.delete();
      m_cyc = 0; m_req = -INF; m_free = 1;
      m_pend = 0; m_wait = 0; m_req_now = 0;
      m_ov = 0; m_to = 0; fv_prev = 0;
      for (int k = 0; k < N; k++) begin
         m_cand[k] = '0; m_stab[k] = '0; m_cap[k] = '0;
         m_cnt[k] = 0; m_upd[k] = -1;
      end
   endtask

   task automatic debounce(input int k);
      ev_t        e;
      logic [7:0] r;
      r = m_cap[k];
      if (r == m_cand[k]) begin
         m_cnt[k] = (m_cnt[k] < DEB) ? m_cnt[k] + 1 : DEB;
      end else begin
         m_cand[k] = r;
         m_cnt[k]  = 1;
      end
      if (m_cnt[k] == DEB && m_cand[k] != m_stab[k]) begin
         e.k = k;
         e.p = m_cand[k] & ~m_stab[k];
         e.r = ~m_cand[k] & m_stab[k];
         if (q.size() < FD) q.push_back(e);
         else               m_ov = 1;
         m_stab[k] = m_cand[k];
      end
   endtask

   task automatic model_step();
      bit tick;
      bit pop;
      m_cyc++;
      tick = (m_cyc % PER) == 0;
      pop  = event_ready && q.size() != 0;
      m_req_now = 0;
      if (clear_flags) begin
         m_ov = 0;
         m_to = 0;
      end
      if (pop) void'(q.pop_front());
      for (int k = 0; k < N; k++)
         if (m_upd[k] == m_cyc) debounce(k);
      if (m_wait) begin
         if (fetch_valid && !fv_prev && m_cyc >= m_req + 2) begin
            for (int k = 0; k < N; k++) begin
               m_cap[k] = data[8*(N-k)-1 -: 8];
               m_upd[k] = m_cyc + 1 + k;
            end
            m_free = m_cyc + N + 1;
            m_wait = 0;
         end else if (m_cyc == m_req + TMO) begin
            m_to   = 1;
            m_free = m_cyc + 1;
            m_wait = 0;
         end
      end
      if (!m_wait && m_cyc >= m_free && enable && (m_pend || tick)) begin
         m_req     = m_cyc;
         m_wait    = 1;
         m_free    = INF;
         m_pend    = 0;
         m_req_now = 1;
      end else if (tick) begin
         m_pend = 1;
      end
      fv_prev = fetch_valid;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_ni);
         if (!rst_ni) model_reset();
         else         model_step();
      end
   end

   function automatic logic [W-1:0] m_buttons();
      logic [W-1:0] b;
      b = '0;
      for (int k = 0; k < N; k++) b[8*(N-k)-1 -: 8] = m_stab[k];
      return b;
   endfunction

   always @(negedge clk) begin
      if (rst_ni) begin
         chk("start_fetch", start_fetch, m_req_now);
         chk("buttons", buttons, m_buttons());
         chk("event_valid", event_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("event_controller", event_controller, q[0].k);
            chk("event_pressed", event_pressed, q[0].p);
            chk("event_released", event_released, q[0].r);
         end
         chk("overflow", overflow, m_ov);
         chk("timeout", timeout, m_to);
      end
   end

   int since_rel;
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) since_rel <= 0;
      else         since_rel <= since_rel + 1;
   end

   task automatic wait_start(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (start_fetch) return;
      end
      errors++;
      $display("FAIL wait_start: no start_fetch within 40 cycles");
   endtask

   task automatic step(input logic [W-1:0] v);
      raw = v;
      repeat (PER) @(negedge clk);
   endtask

   task automatic pop_one();
      event_ready = 1'b1;
      @(negedge clk);
      event_ready = 1'b0;
   endtask

   int n;

   initial begin
      rst_ni      = 1'b0;
      enable      = 1'b1;
      event_ready = 1'b0;
      clear_flags = 1'b0;
      raw         = '0;
      resp_on     = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset start_fetch", start_fetch, 1'b0);
      chk("reset buttons", buttons, 32'h0);
      chk("reset event_valid", event_valid, 1'b0);
      rst_ni = 1'b1;

      wait_start(n);
      chk("first request cycle", since_rel, 16);
      wait_start(n);
      chk("second request cycle", since_rel, 32);
      repeat (10) @(negedge clk);
      chk("idle buttons", buttons, 32'h0);
      chk("idle event_valid", event_valid, 1'b0);

      step(32'h0081_0000);
      chk("press poll1 no event", event_valid, 1'b0);
      step(32'h0081_0000);
      chk("press event_valid", event_valid, 1'b1);
      chk("press controller", event_controller, 2'd1);
      chk("press pressed", event_pressed, 8'h81);
      chk("press released", event_released, 8'h00);
      chk("press buttons", buttons, 32'h0081_0000);
      pop_one();
      repeat (15) @(negedge clk);

      step(32'h0081_1000);
      step(32'h0081_0000);
      step(32'h0081_0000);
      chk("glitch event_valid", event_valid, 1'b0);
      chk("glitch buttons", buttons, 32'h0081_0000);

      step(32'h1122_3344);
      step(32'h1122_3344);
      chk("ovf event_valid", event_valid, 1'b1);
      chk("ovf head controller", event_controller, 2'd0);
      chk("ovf head pressed", event_pressed, 8'h11);
      chk("ovf head released", event_released, 8'h00);
      chk("ovf flag", overflow, 1'b1);
      chk("ovf buttons", buttons, 32'h1122_3344);
      pop_one();
      chk("ovf 2nd controller", event_controller, 2'd1);
      chk("ovf 2nd pressed", event_pressed, 8'h22);
      chk("ovf 2nd released", event_released, 8'h81);
      pop_one();
      chk("ovf drained", event_valid, 1'b0);
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      @(negedge clk);
      chk("ovf cleared", overflow, 1'b0);
      repeat (12) @(negedge clk);

      enable = 1'b0;
      repeat (10) @(negedge clk);
      enable = 1'b1;
      repeat (22) @(negedge clk);

      resp_on = 1'b0;
      wait_start(n);
      n = 0;
      for (int i = 0; i < 20 && !timeout; i++) begin
         @(negedge clk);
         n++;
      end
      chk("timeout latency", n, 8);
      chk("timeout flag", timeout, 1'b1);
      resp_on     = 1'b1;
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      @(negedge clk);
      chk("timeout cleared", timeout, 1'b0);

      step(32'hFFDD_3344);
      wait_start(n);
      repeat (6) @(negedge clk);
      chk("pre-reset queued", event_valid, 1'b1);
      rst_ni = 1'b0;
      #1;
      chk("rst start_fetch", start_fetch, 1'b0);
      chk("rst buttons", buttons, 32'h0);
      chk("rst event_valid", event_valid, 1'b0);
      chk("rst controller", event_controller, 2'd0);
      chk("rst pressed", event_pressed, 8'h0);
      chk("rst released", event_released, 8'h0);
      chk("rst overflow", overflow, 1'b0);
      chk("rst timeout", timeout, 1'b0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      wait_start(n);
      chk("post-reset request cycle", since_rel, 16);
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nes_controller_poller.md
Name: nes_controller_poller

Overview:
- Scheduler and change detector downstream of nes_controller_interface.
- Issues periodic fetch requests and captures each controller's 8-bit button byte when the fetch completes.
- Debounces each byte over consecutive polls.
- Pushes per-controller press/release events into a small valid/ready FIFO for game or CPU logic to consume.

Parameters:
- NUM_CONTROLLERS, 4, number of controller slices on data_LIST_i (1..8).
- POLL_PERIOD, 200000, clk cycles between successive start_fetch_o pulses (>=2).
- DEBOUNCE_SAMPLES, 2, consecutive identical samples required to accept a new byte (1..15; 1 = no debounce).
- FETCH_TIMEOUT, 4096, clk cycles to wait for fetch completion before abandoning it.
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock.
- rst_ni  input  1  reset.
- enable_i  input  1  polling enable.
- start_fetch_o  output  1  fetch request to interface start_fetch_i.
- fetch_valid_i  input  1  interface valid_o.
- data_LIST_i  input  8*NUM_CONTROLLERS  interface data_LIST_o; controller k at bits [8*(NUM_CONTROLLERS-k)-1 -: 8], k=0 is the MSB byte.
- buttons_LIST_o  output  8*NUM_CONTROLLERS  debounced stable bytes, same packing.
- event_valid_o  output  1  FIFO non-empty.
- event_ready_i  input  1  consumer pops head when high with event_valid_o.
- event_controller_o  output  max(1,$clog2(NUM_CONTROLLERS))  controller index k of head event.
- event_pressed_o  output  8  bits that went 0->1.
- event_released_o  output  8  bits that went 1->0.
- overflow_o  output  1  sticky: an event was dropped.
- timeout_o  output  1  sticky: a fetch timed out.
- clear_flags_i  input  1  clears overflow_o and timeout_o.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_ni).
- Reset values: all outputs 0, FIFO empty, all debounce candidates/counts/stable bytes 0, state IDLE, period counter loaded with POLL_PERIOD-1.
- Period counter: free-running; decrements every cycle and reloads POLL_PERIOD-1 at 0, independent of state. A zero crossing sets a pending flag.
- States: IDLE, REQUEST, WAIT, PROCESS.
- IDLE -> REQUEST when pending and enable_i; pending cleared on entry. With enable_i low, pending is held, not lost (at most one).
- REQUEST: start_fetch_o=1 for exactly one cycle -> WAIT. The timeout counter clears.
- WAIT: a rising edge of fetch_valid_i (registered previous value 0, current 1) -> PROCESS; data_LIST_i is sampled into a capture register that same cycle.
- WAIT timeout: after FETCH_TIMEOUT cycles with no edge -> IDLE, set timeout_o; debounce state untouched.
- PROCESS: one controller per cycle, k = 0..NUM_CONTROLLERS-1, then -> IDLE. Edge at cycle t: controller k updated at t+1+k; its event is visible on event_valid_o at t+2+k if the FIFO was empty.
- Overrun: if the fetch+process time exceeds POLL_PERIOD, the next request issues on the first IDLE cycle; there is no backlog beyond one pending.
- Debounce per controller, on raw byte r:
  - r==candidate: count saturates at DEBOUNCE_SAMPLES.
  - r!=candidate: candidate=r, count=1.
  - count (post-update) == DEBOUNCE_SAMPLES and candidate != stable: stable<=candidate; push {k, candidate&~stable, ~candidate&stable}.
  - Otherwise no push.
- FIFO: show-ahead; the head is on the event_* outputs while event_valid_o=1.
  - Push accepted when not full, or when full with a pop in the same cycle.
  - Push rejected: set overflow_o; stable still updates.
  - Pop on empty ignored. Pointers wrap modulo FIFO_DEPTH.
- clear_flags_i: clears sticky flags next cycle. A set event in the same cycle wins.
- enable_i low during WAIT/PROCESS: the in-flight fetch completes normally.
- Async reset mid-operation: immediate return to reset values; a partially processed poll is discarded.

Test Plan:
- Reset, enable_i=1, POLL_PERIOD=16, interface model returning 0x00 -> first start_fetch_o pulse 16 cycles after rst_ni rises, then every 16 cycles; no events, buttons_LIST_o=0.
- DEBOUNCE_SAMPLES=2, controller 1 byte goes 0x00->0x81 -> no event after poll 1; after poll 2 one event {k=1, pressed=0x81, released=0x00}; buttons byte 1 = 0x81.
- Glitch 0x00->0x10->0x00 on successive polls -> no event, stable stays 0x00.
- All 4 controllers change, FIFO_DEPTH=2, event_ready_i=0 -> 2 events queued for k=0,1; overflow_o=1; all 4 stable bytes updated; clear_flags_i pulse -> overflow_o=0.
- fetch_valid_i held 0, FETCH_TIMEOUT=8 -> timeout_o=1 eight cycles after REQUEST; next period issues a new request.
- Drop rst_ni mid-PROCESS with events queued -> all outputs 0 immediately, FIFO empty; the first request comes POLL_PERIOD cycles after release.
